// File: rtl/can_tx_frame_serializer.sv
// CAN 2.0 transmit frame serializer: emits the unstuffed bit stream SOF..EOF+IFS, one bit per bit_tick.
// Optional build macro CAN_TX_EXT_ID_EN enables 29-bit extended identifiers when ide=1.
module can_tx_frame_serializer #(
  parameter int EOF_BITS = 7,
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bit_tick,
  input  logic        i_start,
  input  logic [28:0] i_id,
  input  logic        i_ide,
  input  logic        i_rtr,
  input  logic [3:0]  i_dlc,
  input  logic [63:0] i_data,
  input  logic        i_abort,
  input  logic        i_ack_rx,
  input  logic [14:0] i_crc_in,
  output logic        o_crc_init,
  output logic        o_crc_en,
  output logic        o_crc_data_bit,
  output logic        o_tx_bit,
  output logic        o_tx_stuff_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ack_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_SOF, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS
  } stateT;

  stateT       r_state, w_stateNext;
  logic [6:0]  r_bitCnt, w_bitCntNext;
  logic        r_crcInit, r_done, r_ackErr;
  logic        w_doneNext, w_ackErrNext;
  logic        r_rtr;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;
  logic [31:0] w_arbVec;
  logic [6:0]  w_arbLen, w_dataLen, w_fieldLen;
  logic [5:0]  w_ctrlVec;
  logic        w_lastBit, w_accept, w_txBit;

  assign w_accept = (r_state == S_IDLE) && i_start && !i_abort;

  // Arbitration field is left-aligned in w_arbVec so both formats share one bit index.
`ifdef CAN_TX_EXT_ID_EN
  logic [28:0] r_id;
  logic        r_ide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id  <= '0;
      r_ide <= 1'b0;
    end else if (w_accept) begin
      r_id  <= i_id;
      r_ide <= i_ide;
    end
  end

  assign w_arbVec = r_ide ? {r_id[28:18], 2'b11, r_id[17:0], r_rtr}
                          : {r_id[10:0], r_rtr, 20'd0};
  assign w_arbLen = r_ide ? 7'd32 : 7'd12;
`else
  logic [10:0] r_id;
  logic        w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id <= '0;
    end else if (w_accept) begin
      r_id <= i_id[10:0];
    end
  end

  assign w_arbVec = {r_id, r_rtr, 20'd0};
  assign w_arbLen = 7'd12;
  assign w_unused = ^{i_ide, i_id[28:11]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rtr  <= 1'b0;
      r_dlc  <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_rtr  <= i_rtr;
      r_dlc  <= i_dlc;
      r_data <= i_data;
    end
  end

  // IDE (standard) and r1 (extended) are both dominant, so CTRL is identical for both formats.
  assign w_ctrlVec = {2'b00, r_dlc};
  assign w_dataLen = r_rtr ? 7'd0 : (r_dlc[3] ? 7'd64 : {1'b0, r_dlc[2:0], 3'b000});

  always_comb begin
    w_fieldLen = 7'd1;
    case (r_state)
      S_ARB:   w_fieldLen = w_arbLen;
      S_CTRL:  w_fieldLen = 7'd6;
      S_DATA:  w_fieldLen = w_dataLen;
      S_CRC:   w_fieldLen = 7'd15;
      S_EOF:   w_fieldLen = 7'(EOF_BITS);
      S_IFS:   w_fieldLen = 7'(IFS_BITS);
      default: w_fieldLen = 7'd1;
    endcase
  end

  assign w_lastBit = (r_bitCnt == (w_fieldLen - 7'd1));

  always_comb begin
    w_txBit = 1'b1;
    case (r_state)
      S_SOF:   w_txBit = 1'b0;
      S_ARB:   w_txBit = w_arbVec[5'(7'd31 - r_bitCnt)];
      S_CTRL:  w_txBit = w_ctrlVec[3'(7'd5 - r_bitCnt)];
      S_DATA:  w_txBit = r_data[6'(7'd63 - r_bitCnt)];
      S_CRC:   w_txBit = i_crc_in[4'(7'd14 - r_bitCnt)];
      default: w_txBit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bitCnt  <= '0;
      r_crcInit <= 1'b0;
      r_done    <= 1'b0;
      r_ackErr  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_bitCnt  <= w_bitCntNext;
      r_crcInit <= w_accept;
      r_done    <= w_doneNext;
      r_ackErr  <= w_ackErrNext;
    end
  end

  // Abort outranks everything; otherwise fields advance only on bit_tick.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_doneNext   = 1'b0;
    w_ackErrNext = 1'b0;
    if (i_abort) begin
      w_stateNext  = S_IDLE;
      w_bitCntNext = '0;
    end else if (r_state == S_IDLE) begin
      if (i_start) begin
        w_stateNext  = S_WAIT_SOF;
        w_bitCntNext = '0;
      end
    end else if (i_bit_tick) begin
      if (!w_lastBit) begin
        w_bitCntNext = r_bitCnt + 7'd1;
      end else begin
        w_bitCntNext = '0;
        case (r_state)
          S_WAIT_SOF: w_stateNext = S_SOF;
          S_SOF:      w_stateNext = S_ARB;
          S_ARB:      w_stateNext = S_CTRL;
          S_CTRL:     w_stateNext = (w_dataLen == 7'd0) ? S_CRC : S_DATA;
          S_DATA:     w_stateNext = S_CRC;
          S_CRC:      w_stateNext = S_CRC_DEL;
          S_CRC_DEL:  w_stateNext = S_ACK_SLOT;
          S_ACK_SLOT: begin
            if (i_ack_rx) begin
              w_stateNext  = S_IDLE;
              w_ackErrNext = 1'b1;
            end else begin
              w_stateNext = S_ACK_DEL;
            end
          end
          S_ACK_DEL:  w_stateNext = S_EOF;
          S_EOF:      w_stateNext = S_IFS;
          S_IFS: begin
            w_stateNext = S_IDLE;
            w_doneNext  = 1'b1;
          end
          default:    w_stateNext = S_IDLE;
        endcase
      end
    end
  end

  assign o_tx_bit       = w_txBit;
  assign o_crc_data_bit = w_txBit;
  assign o_crc_en       = i_bit_tick && (r_state inside {S_SOF, S_ARB, S_CTRL, S_DATA});
  assign o_tx_stuff_en  = r_state inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC};
  assign o_busy         = (r_state != S_IDLE);
  assign o_crc_init     = r_crcInit;
  assign o_done         = r_done;
  assign o_ack_err      = r_ackErr;

endmodule
